// File: rtl/feature_loader_if.sv
// Controller handshake, memory read port and systolic row lanes of the feature loader.
// No backpressure: the memory answers one cycle after each read strobe and the array always accepts lanes.
interface feature_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int K      = 2
);
    logic                  Feature_Loader_en;
    logic [ADDR_W-1:0]     systolic_mode_feature_baseaddr;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [K*DATA_W-1:0]   feat_out;
    logic                  feat_valid;
    logic                  busy;
    logic                  feature_Loader_done;

    modport master (
        output Feature_Loader_en, systolic_mode_feature_baseaddr, mem_rdata,
        input  mem_rd_en, mem_addr, feat_out, feat_valid, busy, feature_Loader_done
    );

    modport slave (
        input  Feature_Loader_en, systolic_mode_feature_baseaddr, mem_rdata,
        output mem_rd_en, mem_addr, feat_out, feat_valid, busy, feature_Loader_done
    );
endinterface

// File: rtl/feature_loader.sv
// Fetches one KxK window column-major, then feeds it diagonally skewed into K row lanes; done 2K*K... = K*K+2K+1 cycles after accept.
// No backpressure; define FEATURE_LOADER_ABORT_EN to let a dropped request abort an operation in flight.
module feature_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int K          = 2,
    parameter int ROW_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    feature_loader_if.slave  bus
);
    localparam int             IW    = (K > 1) ? $clog2(K) : 1;
    localparam int             TW    = $clog2(2 * K);
    localparam logic [IW-1:0]  KM1   = IW'(K - 1);
    localparam logic [TW-1:0]  TLAST = TW'(2 * K - 2);

    typedef enum logic [2:0] {IDLE, READ, WAIT, FEED, DONE} state_t;

    state_t                state_q;
    logic                  armed_q;
    logic [ADDR_W-1:0]     base_q;
    logic [IW-1:0]         r_q, c_q;
    logic [TW-1:0]         t_q;
    logic                  cap_vld_q;
    logic [IW-1:0]         cap_r_q, cap_c_q;
    logic [DATA_W-1:0]     win_q [K][K];

    logic                  rd_en_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [K*DATA_W-1:0]   feat_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic [IW-1:0]         r_d, c_d;
    logic                  last_rd;
    logic [ADDR_W-1:0]     addr_d;
    logic [TW-1:0]         t_d;
    logic [K*DATA_W-1:0]   lanes_d;

    assign bus.mem_rd_en           = rd_en_q;
    assign bus.mem_addr            = addr_q;
    assign bus.feat_out            = feat_q;
    assign bus.feat_valid          = valid_q;
    assign bus.busy                = busy_q;
    assign bus.feature_Loader_done = done_q;

    // Column-major walk: row index runs fastest.
    always_comb begin
        last_rd = (r_q == KM1) && (c_q == KM1);
        r_d     = (r_q == KM1) ? '0 : r_q + 1'b1;
        c_d     = (r_q == KM1) ? c_q + 1'b1 : c_q;
        addr_d  = base_q + ADDR_W'(int'(r_d) * ROW_STRIDE) + ADDR_W'(int'(c_d));
    end

    // The element captured on this same edge is taken straight from mem_rdata.
    always_comb begin
        t_d     = (state_q == WAIT) ? '0 : t_q + 1'b1;
        lanes_d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (int'(t_d) == r + c) begin
                    if (cap_vld_q && int'(cap_r_q) == r && int'(cap_c_q) == c)
                        lanes_d[r*DATA_W +: DATA_W] = bus.mem_rdata;
                    else
                        lanes_d[r*DATA_W +: DATA_W] = win_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            base_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            t_q       <= '0;
            cap_vld_q <= 1'b0;
            cap_r_q   <= '0;
            cap_c_q   <= '0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            feat_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    win_q[r][c] <= '0;
        end else begin
            if (!bus.Feature_Loader_en)
                armed_q <= 1'b1;
            cap_vld_q <= 1'b0;
            if (cap_vld_q)
                win_q[cap_r_q][cap_c_q] <= bus.mem_rdata;

            case (state_q)
                IDLE: begin
                    if (bus.Feature_Loader_en && armed_q) begin
                        state_q <= READ;
                        armed_q <= 1'b0;
                        base_q  <= bus.systolic_mode_feature_baseaddr;
                        r_q     <= '0;
                        c_q     <= '0;
                        addr_q  <= bus.systolic_mode_feature_baseaddr;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    cap_vld_q <= 1'b1;
                    cap_r_q   <= r_q;
                    cap_c_q   <= c_q;
                    if (last_rd) begin
                        state_q <= WAIT;
                        rd_en_q <= 1'b0;
                    end else begin
                        r_q    <= r_d;
                        c_q    <= c_d;
                        addr_q <= addr_d;
                    end
                end
                WAIT: begin
                    state_q <= FEED;
                    t_q     <= t_d;
                    feat_q  <= lanes_d;
                    valid_q <= 1'b1;
                end
                FEED: begin
                    if (t_q == TLAST) begin
                        state_q <= DONE;
                        feat_q  <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        t_q    <= t_d;
                        feat_q <= lanes_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

`ifdef FEATURE_LOADER_ABORT_EN
            if (!bus.Feature_Loader_en && (state_q == READ || state_q == WAIT || state_q == FEED)) begin
                state_q   <= IDLE;
                rd_en_q   <= 1'b0;
                valid_q   <= 1'b0;
                feat_q    <= '0;
                busy_q    <= 1'b0;
                cap_vld_q <= 1'b0;
            end
`else
            // Dropping the request mid-operation only re-arms; the window still completes.
`endif
        end
    end
endmodule

// File: tb/tb_feature_loader.sv
// Directed bench for feature_loader with K=2, ROW_STRIDE=4 and a memory holding mem[a]=a+1.
module tb_feature_loader;
`ifdef FEATURE_LOADER_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif
    localparam int PULSE = ABORT ? 9 : 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] mem [64];

    feature_loader_if #(.DATA_W(8), .ADDR_W(6), .K(2)) bus ();

    feature_loader #(.DATA_W(8), .ADDR_W(6), .K(2), .ROW_STRIDE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drop: cycle in which en is lowered (0 = keep high).
    task automatic run_op(input logic [5:0] b, input int drop,
                          input logic [5:0] a0, input logic [5:0] a1,
                          input logic [5:0] a2, input logic [5:0] a3,
                          input logic [15:0] f0, input logic [15:0] f1, input logic [15:0] f2);
        logic [5:0]  ea [4];
        logic [15:0] ef [3];
        logic [15:0] fx;
        bit          ab;
        ea = '{a0, a1, a2, a3};
        ef = '{f0, f1, f2};
        @(negedge clk);
        bus.Feature_Loader_en = 1'b1;
        bus.systolic_mode_feature_baseaddr = b;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            ab = ABORT && drop >= 1 && drop <= 8 && n > drop;
            fx = 16'h0;
            if (!ab && n >= 6 && n <= 8) fx = ef[n-6];
            chk($sformatf("b%0d rd c%0d", b, n), 32'(bus.mem_rd_en), 32'(!ab && n <= 4));
            if (!ab && n <= 4)
                chk($sformatf("b%0d addr c%0d", b, n), 32'(bus.mem_addr), 32'(ea[n-1]));
            chk($sformatf("b%0d valid c%0d", b, n), 32'(bus.feat_valid), 32'(!ab && n >= 6 && n <= 8));
            chk($sformatf("b%0d feat c%0d", b, n), 32'(bus.feat_out), 32'(fx));
            chk($sformatf("b%0d done c%0d", b, n), 32'(bus.feature_Loader_done), 32'(!ab && n == 9));
            chk($sformatf("b%0d busy c%0d", b, n), 32'(bus.busy), 32'(!ab && n <= 9));
            if (n == drop) bus.Feature_Loader_en = 1'b0;
            if (n == 2) bus.systolic_mode_feature_baseaddr = ~b;
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 8'(a + 1);
        bus.Feature_Loader_en = 1'b0;
        bus.systolic_mode_feature_baseaddr = '0;

        repeat (2) @(negedge clk);
        chk("rst rd",    32'(bus.mem_rd_en), 0);
        chk("rst addr",  32'(bus.mem_addr), 0);
        chk("rst feat",  32'(bus.feat_out), 0);
        chk("rst valid", 32'(bus.feat_valid), 0);
        chk("rst busy",  32'(bus.busy), 0);
        chk("rst done",  32'(bus.feature_Loader_done), 0);
        rst = 1'b1;

        run_op(6'd0,  PULSE, 6'd0,  6'd4, 6'd1,  6'd5, 16'h0001, 16'h0502, 16'h0600);
        run_op(6'd1,  PULSE, 6'd1,  6'd5, 6'd2,  6'd6, 16'h0002, 16'h0603, 16'h0700);
        run_op(6'd62, PULSE, 6'd62, 6'd2, 6'd63, 6'd3, 16'h003F, 16'h0340, 16'h0400);

        // Request held through done must not retrigger; one low cycle re-arms.
        run_op(6'd0, 0, 6'd0, 6'd4, 6'd1, 6'd5, 16'h0001, 16'h0502, 16'h0600);
        @(negedge clk);
        chk("rearm busy", 32'(bus.busy), 0);
        chk("rearm rd",   32'(bus.mem_rd_en), 0);
        bus.Feature_Loader_en = 1'b0;
        run_op(6'd4, PULSE, 6'd4, 6'd8, 6'd5, 6'd9, 16'h0005, 16'h0906, 16'h0A00);

        // Reset asserted in the middle of FEED.
        @(negedge clk);
        bus.Feature_Loader_en = 1'b1;
        bus.systolic_mode_feature_baseaddr = 6'd0;
        repeat (7) @(negedge clk);
        chk("pre-rst valid", 32'(bus.feat_valid), 1);
        rst = 1'b0;
        bus.Feature_Loader_en = 1'b0;
        #1;
        chk("mid-rst valid", 32'(bus.feat_valid), 0);
        chk("mid-rst feat",  32'(bus.feat_out), 0);
        chk("mid-rst busy",  32'(bus.busy), 0);
        chk("mid-rst done",  32'(bus.feature_Loader_done), 0);
        chk("mid-rst rd",    32'(bus.mem_rd_en), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("rst hold done %0d", i), 32'(bus.feature_Loader_done), 0);
        end
        rst = 1'b1;
        run_op(6'd1, PULSE, 6'd1, 6'd5, 6'd2, 6'd6, 16'h0002, 16'h0603, 16'h0700);

        // Request dropped in cycle 3: aborts with the macro, ignored without it.
        run_op(6'd0, 3, 6'd0, 6'd4, 6'd1, 6'd5, 16'h0001, 16'h0502, 16'h0600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
